// File: rtl/butterfly_p2s_seq_ctrl_pkg.sv
// Shared types and constants for the p2s/LN output-stage job sequencer.
// Holds the FSM state encoding, the command mode bit positions and the default geometry.
package butterfly_p2s_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCfg    = 3'd1,
        StStream = 3'd2,
        StDrain  = 3'd3,
        StDone   = 3'd4
    } seq_state_e;

    localparam int unsigned MODE_BYPASS    = 0;
    localparam int unsigned MODE_LN        = 1;
    localparam int unsigned LEN_WIDTH      = 16;
    localparam int unsigned NUM_OUTPUT_DEF = 8;
    localparam int unsigned LOG2_NOUT      = $clog2(NUM_OUTPUT_DEF);

    // Output beats a job produces: one per vector when parallel, num_output per vector otherwise.
    function automatic int unsigned beats_per_vec(input logic by_pass, input int unsigned log2_nout);
        return by_pass ? 1 : (1 << log2_nout);
    endfunction

endpackage

// File: rtl/butterfly_seq_cnt.sv
// Loadable up-counter with an equality compare against a terminal value.
// The compare uses the registered count, so it reflects events up to the previous cycle.
module butterfly_seq_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             inc_i,
    input  logic [Width-1:0] term_val_i,
    output logic             at_term_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/butterfly_p2s_seq_ctrl.sv
// Job sequencer in front of the p2s/LN datapath: latches one command, holds the datapath
// configuration for the whole job, gates source vectors in and waits for every output beat.
module butterfly_p2s_seq_ctrl
    import butterfly_p2s_seq_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned NumOutput = NUM_OUTPUT_DEF,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           cmd_vld_i,
    output logic                           cmd_rdy_o,
    input  logic [1:0]                     cmd_mode_i,
    input  logic [LEN_WIDTH-1:0]           cmd_length_i,
    input  logic [CntWidth-1:0]            cmd_num_vec_i,
    input  logic [NumOutput*DataWidth-1:0] src_dat_i,
    input  logic                           src_vld_i,
    output logic                           src_rdy_o,
    output logic                           cfg_is_ln_o,
    output logic                           cfg_by_pass_o,
    output logic [LEN_WIDTH-1:0]           cfg_length_o,
    output logic [NumOutput*DataWidth-1:0] up_dat_o,
    output logic                           up_vld_o,
    input  logic                           up_rdy_i,
    input  logic                           mon_par_fire_i,
    input  logic                           mon_ser_fire_i,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int unsigned Log2Nout = $clog2(NumOutput);
    localparam int unsigned ExpWidth = CntWidth + Log2Nout;

    seq_state_e state_q, state_d;

    logic                 cfg_is_ln_q, cfg_is_ln_d;
    logic                 cfg_by_pass_q, cfg_by_pass_d;
    logic [LEN_WIDTH-1:0] cfg_length_q, cfg_length_d;
    logic [CntWidth-1:0]  num_vec_q, num_vec_d;
    logic [ExpWidth-1:0]  exp_out_q, exp_out_d;

    logic cmd_fire;
    logic in_fire;
    logic out_fire;
    logic streaming;
    logic counting;
    logic cnt_clear;
    logic in_at_last;
    logic out_at_end;

    assign streaming = (state_q == StStream);
    assign counting  = (state_q == StStream) || (state_q == StDrain);
    assign cnt_clear = (state_q == StDone);

    assign cmd_rdy_o = (state_q == StIdle);
    assign cmd_fire  = cmd_vld_i && cmd_rdy_o;

    assign up_dat_o  = src_dat_i;
    assign up_vld_o  = src_vld_i && streaming;
    assign src_rdy_o = up_rdy_i && streaming;
    assign in_fire   = src_vld_i && src_rdy_o;

    // Only the monitor matching the job's output path counts; the other is ignored.
    assign out_fire = counting && (cfg_by_pass_q ? mon_par_fire_i : mon_ser_fire_i);

    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign cfg_is_ln_o   = cfg_is_ln_q;
    assign cfg_by_pass_o = cfg_by_pass_q;
    assign cfg_length_o  = cfg_length_q;

    // Job configuration is only captured on command accept and otherwise held,
    // including past DONE, so late output tails still see the right mode.
    always_comb begin
        cfg_is_ln_d   = cfg_is_ln_q;
        cfg_by_pass_d = cfg_by_pass_q;
        cfg_length_d  = cfg_length_q;
        num_vec_d     = num_vec_q;
        exp_out_d     = exp_out_q;
        if (cmd_fire) begin
            cfg_is_ln_d   = cmd_mode_i[MODE_LN];
            cfg_by_pass_d = cmd_mode_i[MODE_BYPASS];
            cfg_length_d  = cmd_length_i;
            num_vec_d     = cmd_num_vec_i;
            exp_out_d     = cmd_mode_i[MODE_BYPASS] ? ExpWidth'(cmd_num_vec_i)
                                                    : (ExpWidth'(cmd_num_vec_i) << Log2Nout);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    state_d = StCfg;
                end
            end
            StCfg: begin
                state_d = (num_vec_q == '0) ? StDone : StStream;
            end
            StStream: begin
                if (in_fire && in_at_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_at_end) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            cfg_is_ln_q   <= 1'b0;
            cfg_by_pass_q <= 1'b0;
            cfg_length_q  <= '0;
            num_vec_q     <= '0;
            exp_out_q     <= '0;
        end else begin
            state_q       <= state_d;
            cfg_is_ln_q   <= cfg_is_ln_d;
            cfg_by_pass_q <= cfg_by_pass_d;
            cfg_length_q  <= cfg_length_d;
            num_vec_q     <= num_vec_d;
            exp_out_q     <= exp_out_d;
        end
    end

    butterfly_seq_cnt #(
        .Width (CntWidth)
    ) u_in_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_clear),
        .load_val_i ('0),
        .inc_i      (in_fire),
        .term_val_i (num_vec_q - CntWidth'(1)),
        .at_term_o  (in_at_last)
    );

    butterfly_seq_cnt #(
        .Width (ExpWidth)
    ) u_out_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_clear),
        .load_val_i ('0),
        .inc_i      (out_fire),
        .term_val_i (exp_out_q),
        .at_term_o  (out_at_end)
    );

endmodule

// File: tb/tb_butterfly_p2s_seq_ctrl.sv
// Directed bench for the p2s/LN job sequencer; the bench plays source, datapath and
// downstream monitor, and checks each scenario against hand-derived expectations.
module tb_butterfly_p2s_seq_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned NO = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned VW = DW * NO;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic [1:0]    cmd_mode;
    logic [15:0]   cmd_length;
    logic [CW-1:0] cmd_num_vec;
    logic [VW-1:0] src_dat;
    logic          src_vld;
    logic          src_rdy;
    logic          cfg_is_ln;
    logic          cfg_by_pass;
    logic [15:0]   cfg_length;
    logic [VW-1:0] up_dat;
    logic          up_vld;
    logic          up_rdy;
    logic          mon_par_fire;
    logic          mon_ser_fire;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int up_fires, done_cnt, done_cyc, last_fire_cyc, mon_fires, pending;
    int src_idx, data_err, rdy_busy, cfg_chg;

    always #5 clk = ~clk;

    butterfly_p2s_seq_ctrl #(
        .DataWidth (DW),
        .NumOutput (NO),
        .CntWidth  (CW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cmd_vld_i      (cmd_vld),
        .cmd_rdy_o      (cmd_rdy),
        .cmd_mode_i     (cmd_mode),
        .cmd_length_i   (cmd_length),
        .cmd_num_vec_i  (cmd_num_vec),
        .src_dat_i      (src_dat),
        .src_vld_i      (src_vld),
        .src_rdy_o      (src_rdy),
        .cfg_is_ln_o    (cfg_is_ln),
        .cfg_by_pass_o  (cfg_by_pass),
        .cfg_length_o   (cfg_length),
        .up_dat_o       (up_dat),
        .up_vld_o       (up_vld),
        .up_rdy_i       (up_rdy),
        .mon_par_fire_i (mon_par_fire),
        .mon_ser_fire_i (mon_ser_fire),
        .busy_o         (busy),
        .done_o         (done)
    );

    function automatic logic [VW-1:0] make_dat(input int idx);
        logic [VW-1:0] v;
        for (int i = 0; i < NO; i++) begin
            v[i*DW +: DW] = DW'(idx * NO + i + 256);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_stats();
        up_fires = 0; done_cnt = 0; done_cyc = -1; last_fire_cyc = -1;
        mon_fires = 0; pending = 0; src_idx = 0; data_err = 0; rdy_busy = 0; cfg_chg = 0;
    endtask

    task automatic issue_cmd(input logic [1:0] mode, input logic [15:0] len,
                             input logic [CW-1:0] nv);
        int k = 0;
        cmd_mode = mode; cmd_length = len; cmd_num_vec = nv; cmd_vld = 1'b1;
        #1;
        while (!cmd_rdy && k < 50) begin
            tick();
            k++;
        end
        n_vec++;
        if (cmd_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_accept_timeout: cmd_rdy=%b required 1", cmd_rdy);
        end
        tick();
        cmd_vld = 1'b0;
    endtask

    // Plays source + datapath + monitor for one job; stops the cycle after done.
    task automatic run_job(input bit ser_mode, input int fire_cap, input bit stall,
                           input int max_cyc);
        logic        f;
        logic        snap_ln, snap_bp;
        logic [15:0] snap_len;
        snap_ln = cfg_is_ln; snap_bp = cfg_by_pass; snap_len = cfg_length;
        for (int k = 0; k < max_cyc; k++) begin
            if (stall) begin
                src_vld = 1'($urandom_range(0, 1));
                up_rdy  = 1'($urandom_range(0, 1));
            end
            src_dat = make_dat(src_idx);
            f = (pending > 0) && (mon_fires < fire_cap);
            if (ser_mode) begin
                mon_ser_fire = f; mon_par_fire = 1'b1;
            end else begin
                mon_par_fire = f; mon_ser_fire = 1'b1;
            end
            #1;
            if (f) begin
                mon_fires++; pending--; last_fire_cyc = cyc;
            end
            if (src_vld && src_rdy) begin
                if (up_dat !== make_dat(src_idx) || up_vld !== 1'b1) data_err++;
                up_fires++; src_idx++;
                pending += ser_mode ? NO : 1;
            end
            if (cmd_rdy) rdy_busy++;
            if (cfg_is_ln !== snap_ln || cfg_by_pass !== snap_bp || cfg_length !== snap_len)
                cfg_chg++;
            if (done) begin
                done_cnt++; done_cyc = cyc;
            end
            tick();
            if (done_cnt > 0) break;
        end
        mon_par_fire = 1'b0; mon_ser_fire = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_vld = 1'b0; cmd_mode = 2'b00; cmd_length = '0; cmd_num_vec = '0;
        src_dat = '0; src_vld = 1'b1; up_rdy = 1'b1; mon_par_fire = 1'b0; mon_ser_fire = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        n_vec++;
        if ({busy, done, up_vld, src_rdy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctl: busy/done/up_vld/src_rdy=%b required 0000",
                     {busy, done, up_vld, src_rdy});
        end
        n_vec++;
        if ({cfg_is_ln, cfg_by_pass, cfg_length} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_cfg: %h required 0", {cfg_is_ln, cfg_by_pass, cfg_length});
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (cmd_rdy !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: cmd_rdy=%b busy=%b required 1 0", cmd_rdy, busy);
        end
    endtask

    task automatic test_bypass();
        clear_stats();
        src_vld = 1'b1; up_rdy = 1'b1;
        issue_cmd(2'b01, 16'd0, 16'd3);
        #1;
        n_vec++;
        if ({cfg_by_pass, cfg_is_ln, up_vld, cmd_rdy} !== 4'b1000) begin
            n_err++;
            $display("FAIL bypass_cfg: bp/ln/up_vld/cmd_rdy=%b required 1000",
                     {cfg_by_pass, cfg_is_ln, up_vld, cmd_rdy});
        end
        run_job(1'b0, 1000, 1'b0, 60);
        n_vec++;
        if (up_fires != 3 || src_idx != 3 || data_err != 0) begin
            n_err++;
            $display("FAIL bypass_in: fires=%0d data_err=%0d required 3 0", up_fires, data_err);
        end
        n_vec++;
        if (done_cnt != 1 || mon_fires != 3) begin
            n_err++;
            $display("FAIL bypass_done: done=%0d par=%0d required 1 3", done_cnt, mon_fires);
        end
        n_vec++;
        if (done_cyc - last_fire_cyc != 2) begin
            n_err++;
            $display("FAIL bypass_lat: %0d required 2", done_cyc - last_fire_cyc);
        end
        n_vec++;
        if (cfg_chg != 0 || cfg_by_pass !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL bypass_hold: chg=%0d bp=%b done=%b required 0 1 0",
                     cfg_chg, cfg_by_pass, done);
        end
    endtask

    task automatic test_serial_count();
        clear_stats();
        src_vld = 1'b1; up_rdy = 1'b1;
        issue_cmd(2'b00, 16'd0, 16'd2);
        run_job(1'b1, 15, 1'b0, 40);
        n_vec++;
        if (done_cnt != 0 || mon_fires != 15 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL ser_15: done=%0d ser=%0d busy=%b required 0 15 1",
                     done_cnt, mon_fires, busy);
        end
        run_job(1'b1, 16, 1'b0, 20);
        n_vec++;
        if (done_cnt != 1 || mon_fires != 16 || up_fires != 2) begin
            n_err++;
            $display("FAIL ser_16: done=%0d ser=%0d in=%0d required 1 16 2",
                     done_cnt, mon_fires, up_fires);
        end
        n_vec++;
        if (done_cyc - last_fire_cyc != 2) begin
            n_err++;
            $display("FAIL ser_lat: %0d required 2", done_cyc - last_fire_cyc);
        end
    endtask

    task automatic test_ln_cfg();
        clear_stats();
        src_vld = 1'b1; up_rdy = 1'b1;
        issue_cmd(2'b10, 16'd64, 16'd1);
        #1;
        n_vec++;
        if ({cfg_is_ln, cfg_by_pass, up_vld} !== 3'b100 || cfg_length !== 16'd64) begin
            n_err++;
            $display("FAIL ln_cfg: ln/bp/up_vld=%b len=%0d required 100 64",
                     {cfg_is_ln, cfg_by_pass, up_vld}, cfg_length);
        end
        run_job(1'b1, 1000, 1'b0, 60);
        n_vec++;
        if (done_cnt != 1 || mon_fires != 8 || up_fires != 1) begin
            n_err++;
            $display("FAIL ln_done: done=%0d ser=%0d in=%0d required 1 8 1",
                     done_cnt, mon_fires, up_fires);
        end
        n_vec++;
        if (done_cyc - last_fire_cyc != 2 || cfg_chg != 0) begin
            n_err++;
            $display("FAIL ln_lat_hold: lat=%0d chg=%0d required 2 0",
                     done_cyc - last_fire_cyc, cfg_chg);
        end
        n_vec++;
        if (cfg_length !== 16'd64 || cfg_is_ln !== 1'b1) begin
            n_err++;
            $display("FAIL ln_tail: len=%0d ln=%b required 64 1", cfg_length, cfg_is_ln);
        end
    endtask

    task automatic test_zero_vec();
        src_vld = 1'b1; up_rdy = 1'b1;
        issue_cmd(2'b11, 16'd5, 16'd0);
        n_vec++;
        if (done !== 1'b0 || up_vld !== 1'b0) begin
            n_err++;
            $display("FAIL zero_cfg: done=%b up_vld=%b required 0 0", done, up_vld);
        end
        tick();
        n_vec++;
        if (done !== 1'b1 || up_vld !== 1'b0 || src_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_done: done=%b up_vld=%b src_rdy=%b required 1 0 0",
                     done, up_vld, src_rdy);
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || cmd_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL zero_idle: done=%b cmd_rdy=%b required 0 1", done, cmd_rdy);
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        issue_cmd(2'b01, 16'd7, 16'd4);
        cmd_mode = 2'b10; cmd_length = 16'd32; cmd_num_vec = 16'd1; cmd_vld = 1'b1;
        run_job(1'b0, 1000, 1'b1, 300);
        src_vld = 1'b1; up_rdy = 1'b1;
        n_vec++;
        if (up_fires != 4 || src_idx != 4 || data_err != 0) begin
            n_err++;
            $display("FAIL b2b_data: fires=%0d data_err=%0d required 4 0", up_fires, data_err);
        end
        n_vec++;
        if (done_cnt != 1 || rdy_busy != 0) begin
            n_err++;
            $display("FAIL b2b_busy: done=%0d rdy_busy=%0d required 1 0", done_cnt, rdy_busy);
        end
        n_vec++;
        if (cmd_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_rdy: cmd_rdy=%b required 1", cmd_rdy);
        end
        tick();
        cmd_vld = 1'b0;
        n_vec++;
        if (cmd_rdy !== 1'b0 || cfg_length !== 16'd32 || cfg_is_ln !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: rdy=%b len=%0d ln=%b required 0 32 1",
                     cmd_rdy, cfg_length, cfg_is_ln);
        end
        clear_stats();
        run_job(1'b1, 1000, 1'b0, 60);
        n_vec++;
        if (done_cnt != 1 || up_fires != 1 || mon_fires != 8) begin
            n_err++;
            $display("FAIL b2b_second: done=%0d in=%0d ser=%0d required 1 1 8",
                     done_cnt, up_fires, mon_fires);
        end
    endtask

    task automatic test_reset_mid_job();
        clear_stats();
        src_vld = 1'b1; up_rdy = 1'b1;
        issue_cmd(2'b01, 16'd9, 16'd4);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, up_vld, src_rdy, cmd_rdy} !== 5'b00001) begin
            n_err++;
            $display("FAIL rst_mid_ctl: busy/done/up_vld/src_rdy/cmd_rdy=%b required 00001",
                     {busy, done, up_vld, src_rdy, cmd_rdy});
        end
        n_vec++;
        if ({cfg_is_ln, cfg_by_pass, cfg_length} !== 18'd0) begin
            n_err++;
            $display("FAIL rst_mid_cfg: %h required 0", {cfg_is_ln, cfg_by_pass, cfg_length});
        end
        #2;
        rst_n = 1'b1;
        tick();
        clear_stats();
        issue_cmd(2'b01, 16'd0, 16'd2);
        run_job(1'b0, 1000, 1'b0, 60);
        n_vec++;
        if (up_fires != 2 || done_cnt != 1 || done_cyc - last_fire_cyc != 2) begin
            n_err++;
            $display("FAIL rst_mid_job: in=%0d done=%0d lat=%0d required 2 1 2",
                     up_fires, done_cnt, done_cyc - last_fire_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_serial_count();
        test_ln_cfg();
        test_zero_vec();
        test_back_to_back();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/butterfly_p2s_seq_ctrl.md
Name: butterfly_p2s_seq_ctrl

Overview:
- Command-driven sequencer in front of the parallel-to-serial / layer-norm output stage (p2s+LN datapath).
- Accepts one job descriptor at a time: mode, LN length and number of input vectors.
- Holds the datapath configuration (is_ln, by_pass, length) stable for the whole job, gates source vectors into the datapath and counts downstream beats.
- Emits a done pulse only after the last output beat has left, so configuration never changes while data is in flight.

Parameters:
- data_width, 16, element width in bits.
- num_output, 8, elements per parallel vector; power of two, at least 2.
- cnt_width, 16, width of the vector-count field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready; high only in IDLE
- cmd_mode  in  2  bit0 = by_pass (parallel output), bit1 = is_ln
- cmd_length  in  16  LN normalisation length, forwarded unchanged
- cmd_num_vec  in  cnt_width  number of input vectors in the job
- src_dat  in  num_output*data_width  source vector
- src_vld  in  1  source valid
- src_rdy  out  1  source ready
- cfg_is_ln  out  1  to datapath is_ln
- cfg_by_pass  out  1  to datapath by_pass
- cfg_length  out  16  to datapath length
- up_dat  out  num_output*data_width  to datapath up_dat
- up_vld  out  1  to datapath up_vld
- up_rdy  in  1  from datapath up_rdy
- mon_par_fire  in  1  dn_parallel_vld & dn_parallel_rdy, observed
- mon_ser_fire  in  1  dn_serial_vld & dn_serial_rdy, observed
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset values: state IDLE, all cfg_* 0, up_vld 0, src_rdy 0, busy 0, done 0, both counters 0; cmd_rdy 1 once reset is released.
- up_dat = src_dat, combinational.
- up_vld = src_vld & (state==STREAM).
- src_rdy = up_rdy & (state==STREAM).
- in_fire = src_vld & src_rdy.
- FSM states: IDLE, CFG, STREAM, DRAIN, DONE.
- IDLE: on cmd_vld&cmd_rdy, register mode/length/num_vec.
  - Compute exp_out = by_pass ? num_vec : num_vec*num_output, as a left shift by log2(num_output).
  - exp_out width is cnt_width+log2(num_output); no overflow is possible.
  - Go to CFG.
- CFG: exactly one cycle; cfg_* outputs now show the new job so the datapath sees a stable mode before the first data beat.
  - If num_vec==0, go to DONE; otherwise go to STREAM.
- STREAM: in_cnt increments on in_fire.
  - When in_fire and in_cnt==num_vec-1, go to DRAIN. src_rdy is low from the next cycle.
- Output counting runs in STREAM and DRAIN:
  - out_cnt increments on mon_par_fire when by_pass=1, on mon_ser_fire when by_pass=0.
  - The non-selected monitor input is ignored.
- DRAIN: when out_cnt==exp_out, go to DONE.
  - A fire in the same cycle as the last input fire is counted normally.
  - The comparison uses the registered out_cnt; done therefore lags the last output beat by 2 cycles.
- DONE: done=1 for one cycle, both counters clear, go to IDLE.
  - cfg_* hold their values until the next command is accepted, so in-flight tails remain correct.
- Latency: command accept to first possible up_vld is 2 cycles (IDLE→CFG→STREAM).
- Only one command is in flight at a time; cmd_rdy is low from CFG through DONE.
- A source beat offered outside STREAM is held off (src_rdy=0); it is never dropped.
- Reset mid-job: asynchronous return to IDLE with all outputs at reset values. Flushing the datapath is the system's responsibility.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=0, CFG=1, STREAM=2, DRAIN=3, DONE=4),
  - mode bit positions (MODE_BYPASS=0, MODE_LN=1),
  - the localparam LOG2_NOUT = $clog2(num_output).
- One natural sub-module: butterfly_seq_cnt, a loadable up-counter with terminal-compare output. It is instantiated twice, once for input vectors and once for output beats.

Test Plan:
- Mode 2'b01, num_vec=3, source always valid, downstream always ready:
  - exactly 3 up_vld fires with cfg_by_pass=1, cfg_is_ln=0;
  - done once, 2 cycles after the 3rd mon_par_fire.
- Mode 2'b00, num_vec=2, num_output=8:
  - done only after 16 mon_ser_fire;
  - done absent after 15 fires.
- Mode 2'b10, cmd_length=64, num_vec=1:
  - cfg_is_ln=1 and cfg_length=64 are visible in CFG, before up_vld, and stay constant through DONE;
  - done follows 8 serial fires.
- num_vec=0, any mode: CFG→DONE, no up_vld; done pulses 2 cycles after command accept.
- Random src_vld / up_rdy stalls with a second cmd_vld held high during a job:
  - cmd_rdy stays low until IDLE; the second command is accepted the cycle after done;
  - source data is not lost or duplicated.
- rst_n asserted mid-STREAM after 1 of 4 vectors: all outputs take reset values immediately; a fresh job then completes normally.
